// File: rtl/param_arbiter.sv
// param_arbiter: N-requester arbiter with registered one-hot grants, run-time
// selectable fixed-priority / round-robin policy and an optional hold limit.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner, gnt=0; any request is granted on the next edge
// GRANT | owner (gnt_id) holds the resource; hold_cnt counts extra cycles
module param_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           rr_en,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   gnt_q, gnt_d;

  logic [IDW-1:0] own_inc;
  logic [N-1:0]   cand;
  logic [IDW-1:0] start;
  logic           expired;

  // First set bit of c, scanning upward from start and wrapping at N.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] c, input logic [IDW-1:0] from);
    logic found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(from) + k;
      if (idx >= N) idx = idx - N;
      if (!found && c[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
  endfunction

  // Next-state, owner, hold counter and round-robin pointer decision.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    cand    = req;
    start   = rr_en ? ptr_q : '0;
    own_inc = (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
    expired = (MAX_HOLD > 0) && (hold_q == HOLD_LAST);

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          owner_d = pick(req, start);
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (req[owner_q] && !expired) begin
          if (MAX_HOLD > 0) hold_d = hold_q + 1'b1;
        end else begin
          // The scan resumes just past the outgoing owner, which is also
          // where the pointer lands once ownership moves on.
          start = rr_en ? own_inc : '0;
          if (req[owner_q]) cand[owner_q] = 1'b0;
          if (|cand) begin
            owner_d = pick(cand, start);
            hold_d  = '0;
            ptr_d   = own_inc;
          end else if (req[owner_q]) begin
            // Nobody else waiting: the same owner starts a fresh hold window.
            hold_d = '0;
          end else begin
            state_d = IDLE;
            owner_d = '0;
            hold_d  = '0;
            ptr_d   = own_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
        hold_d  = '0;
      end
    endcase

    gnt_d = '0;
    if (state_d == GRANT) gnt_d[owner_d] = 1'b1;
  end

  // State and grant registers; reset clears the grant immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      hold_q  <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == GRANT);
  assign gnt_id    = owner_q;

endmodule

// File: tb/tb_param_arbiter.sv
// Testbench for param_arbiter: table-driven vectors plus directed multi-cycle
// sequences on N=4 instances, and a randomised invariant run on an N=5 instance.
module tb_param_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic [3:0] req_a = '0, req_b = '0, req_c = '0;
  logic       rr_a = 1'b0, rr_b = 1'b0, rr_c = 1'b0;
  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic       v_a, v_b, v_c;
  logic [1:0] id_a, id_b, id_c;

  logic [4:0] req_d = '0;
  logic       rr_d = 1'b0;
  logic [4:0] gnt_d;
  logic       v_d;
  logic [2:0] id_d;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock generation.
  always #5 clk = ~clk;

  param_arbiter #(.N(4), .MAX_HOLD(8)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .rr_en(rr_a),
    .gnt(gnt_a), .gnt_valid(v_a), .gnt_id(id_a));

  param_arbiter #(.N(4), .MAX_HOLD(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .rr_en(rr_b),
    .gnt(gnt_b), .gnt_valid(v_b), .gnt_id(id_b));

  param_arbiter #(.N(4), .MAX_HOLD(1)) dut_c (
    .clk(clk), .reset(reset), .req(req_c), .rr_en(rr_c),
    .gnt(gnt_c), .gnt_valid(v_c), .gnt_id(id_c));

  param_arbiter #(.N(5), .MAX_HOLD(3)) dut_d (
    .clk(clk), .reset(reset), .req(req_d), .rr_en(rr_d),
    .gnt(gnt_d), .gnt_valid(v_d), .gnt_id(id_d));

  typedef struct {
    logic [3:0] req;
    logic       rr;
    logic [3:0] gnt;
    logic [1:0] id;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] id_of(input logic [4:0] g);
    id_of = 0;
    for (int i = 0; i < 5; i++) if (g[i]) id_of = i;
  endfunction

  initial begin
    int t3_ids [6];
    int wait_cnt [5];
    int maxw;
    int exp_id;

    // req, rr_en, expected gnt, expected gnt_id after the next edge (MAX_HOLD=8)
    tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 2'd0};
    tbl[1]  = '{4'b1010, 1'b0, 4'b0010, 2'd1};
    tbl[2]  = '{4'b1010, 1'b0, 4'b0010, 2'd1};
    tbl[3]  = '{4'b1000, 1'b0, 4'b1000, 2'd3};
    tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 2'd0};
    tbl[5]  = '{4'b0110, 1'b1, 4'b0010, 2'd1};
    tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 2'd2};
    tbl[7]  = '{4'b0011, 1'b1, 4'b0001, 2'd0};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 2'd0};
    tbl[9]  = '{4'b0011, 1'b1, 4'b0010, 2'd1};
    tbl[10] = '{4'b0011, 1'b0, 4'b0010, 2'd1};
    tbl[11] = '{4'b0101, 1'b0, 4'b0001, 2'd0};
    tbl[12] = '{4'b0101, 1'b1, 4'b0001, 2'd0};
    tbl[13] = '{4'b0100, 1'b1, 4'b0100, 2'd2};
    tbl[14] = '{4'b0010, 1'b0, 4'b0010, 2'd1};
    tbl[15] = '{4'b0000, 1'b0, 4'b0000, 2'd0};
    tbl[16] = '{4'b0100, 1'b0, 4'b0100, 2'd2};
    tbl[17] = '{4'b0011, 1'b0, 4'b0001, 2'd0};
    tbl[18] = '{4'b1001, 1'b1, 4'b0001, 2'd0};
    tbl[19] = '{4'b1000, 1'b1, 4'b1000, 2'd3};
    tbl[20] = '{4'b0000, 1'b1, 4'b0000, 2'd0};
    tbl[21] = '{4'b1100, 1'b1, 4'b0100, 2'd2};
    tbl[22] = '{4'b0000, 1'b1, 4'b0000, 2'd0};
    tbl[23] = '{4'b1001, 1'b1, 4'b1000, 2'd3};
    tbl[24] = '{4'b0000, 1'b1, 4'b0000, 2'd0};
    tbl[25] = '{4'b1001, 1'b0, 4'b0001, 2'd0};
    tbl[26] = '{4'b0000, 1'b0, 4'b0000, 2'd0};

    t3_ids = '{0, 1, 2, 3, 0, 1};

    // Power-on reset state.
    repeat (2) @(negedge clk);
    chk("por_gnt", gnt_a, 0);
    chk("por_valid", v_a, 0);
    chk("por_id", id_a, 0);
    reset = 1'b0;

    // Table-driven vectors on the MAX_HOLD=8 instance.
    for (int i = 0; i < NV; i++) begin
      req_a = tbl[i].req;
      rr_a  = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), gnt_a, tbl[i].gnt);
      chk($sformatf("tbl%0d_id", i), id_a, tbl[i].id);
      chk($sformatf("tbl%0d_valid", i), v_a, |tbl[i].gnt);
    end

    // Hold limit: two requesters alternate every 8 cycles.
    req_a = 4'b0011;
    rr_a  = 1'b0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      exp_id = (c < 8 || c >= 16) ? 0 : 1;
      chk($sformatf("hold_id_c%0d", c), id_a, exp_id);
      chk($sformatf("hold_gnt_c%0d", c), gnt_a, 32'd1 << exp_id);
    end
    req_a = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("solo_gnt_c%0d", c), gnt_a, 4'b0001);
    end
    req_a = 4'b0000;
    @(negedge clk);
    chk("solo_release", gnt_a, 0);

    // Reset mid-grant (owner 3, pointer left at 1) drops gnt at once.
    req_a = 4'b1000;
    @(negedge clk);
    req_a = 4'b1111;
    @(negedge clk);
    chk("pre_reset_owner", id_a, 3);
    reset = 1'b1;
    #1;
    chk("rst_async_gnt", gnt_a, 0);
    chk("rst_async_valid", v_a, 0);
    chk("rst_async_id", id_a, 0);
    @(negedge clk);
    chk("rst_held_gnt", gnt_a, 0);
    reset = 1'b0;
    rr_a  = 1'b1;
    @(negedge clk);
    chk("rst_first_gnt", gnt_a, 4'b0001);
    req_a = 4'b0000;
    rr_a  = 1'b0;
    @(negedge clk);

    // Unlimited hold with fixed priority.
    rr_b  = 1'b0;
    req_b = 4'b1010;
    @(negedge clk);
    chk("fix_first", gnt_b, 4'b0010);
    repeat (12) @(negedge clk);
    chk("fix_unlimited", gnt_b, 4'b0010);
    req_b = 4'b1000;
    @(negedge clk);
    chk("fix_handover_gnt", gnt_b, 4'b1000);
    chk("fix_handover_id", id_b, 3);
    req_b = 4'b0000;
    @(negedge clk);
    chk("fix_idle_gnt", gnt_b, 0);
    chk("fix_idle_valid", v_b, 0);

    // Round-robin with a one-cycle hold limit rotates every cycle.
    rr_c  = 1'b1;
    req_c = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rr_seq%0d", c), id_c, t3_ids[c]);
    end
    req_c = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rr_regrant%0d", c), gnt_c, 4'b0100);
    end
    req_c = 4'b0000;
    @(negedge clk);
    chk("rr_idle", gnt_c, 0);

    // Random run on N=5, MAX_HOLD=3: invariants and starvation bound.
    foreach (wait_cnt[i]) wait_cnt[i] = 0;
    rr_d = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      if (reset) begin
        chk("rnd_reset_gnt", gnt_d, 0);
        foreach (wait_cnt[i]) wait_cnt[i] = 0;
      end else begin
        chk("rnd_valid_vs_req", v_d, |req_d);
        chk("rnd_onehot0", $onehot0(gnt_d), 1);
        chk("rnd_valid_eq_or", v_d, |gnt_d);
        chk("rnd_gnt_without_req", gnt_d & ~req_d, 0);
        chk("rnd_id", id_d, id_of(gnt_d));
        if (cyc < 5000) begin
          maxw = 0;
          for (int i = 0; i < 5; i++) begin
            if (req_d[i] && !gnt_d[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
          end
          chk("rnd_starvation", (maxw <= 13), 1);
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (!req_d[i]) req_d[i] = ($urandom_range(2) == 0);
        else if (gnt_d[i]) req_d[i] = ($urandom_range(3) != 0);
      end
      rr_d = (cyc < 5000) ? 1'b1 : 1'($urandom_range(1));
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(199) == 0) begin
        reset = 1'b1;
        #1;
        chk("rnd_async_reset", {gnt_d, v_d, id_d}, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
